// File: rtl/i2c_slave_regs_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_slave_regs_pkg;

   // Target FSM states; encoding is exported on the debug state port.
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WRITE     = 4'd5,
      ST_WRITE_ACK = 4'd6,
      ST_READ      = 4'd7,
      ST_READ_ACK  = 4'd8,
      ST_WAIT      = 4'd9
   } i2c_state_e;

   localparam logic       I2C_ACK   = 1'b0;
   localparam logic       I2C_NACK  = 1'b1;
   localparam logic [3:0] LAST_BIT  = 4'd7;   // bit counter value on the 8th scl rise
   localparam logic [3:0] BYTE_DONE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes scl/sda into clk and derives bus edge / condition pulses.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Next-state of the synchronizer chains and the one-clk history used for edges.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
   end

   // Lines reset to the idle (released) level so reset release never fakes an edge on an idle bus.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   // START/STOP require scl high on both samples, so an sda edge racing scl is not a condition.
   assign scl_rise  =  scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s &  scl_prev_q;
   assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
   assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target serving a byte-addressed register space through a host pulse port.
module i2c_slave_regs
   import i2c_slave_regs_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h77,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       addressed,
   output logic [3:0] state
);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl),
      .sda_in    (sda),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_state_e state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic       sda_oe_q, sda_oe_d;      // 1 = pull sda low
   logic       rw_q, rw_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_wdata_q, reg_wdata_d;
   logic       reg_we_q, reg_we_d;
   logic       reg_re_q, reg_re_d;
   logic       rd_load_q, rd_load_d;    // reg_rdata is valid on the clk after reg_re
   logic       busy_q, busy_d;
   logic       addressed_q, addressed_d;
   logic [7:0] byte_in;

   assign byte_in = {shift_q[6:0], sda_s};

   // FSM next-state: bus conditions take priority over any coincident scl edge.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      sda_oe_d    = sda_oe_q;
      rw_d        = rw_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      reg_re_d    = 1'b0;
      rd_load_d   = reg_re_q;
      busy_d      = busy_q;
      addressed_d = addressed_q;

      if (rd_load_q) shift_d = reg_rdata;

      if (start_det) begin
         state_d     = ST_ADDR;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         addressed_d = 1'b0;
         busy_d      = 1'b1;
      end else if (stop_det) begin
         state_d     = ST_IDLE;
         sda_oe_d    = 1'b0;
         busy_d      = 1'b0;
         addressed_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                     state_d     = ST_ADDR_ACK;
                     addressed_d = 1'b1;
                     rw_d        = byte_in[0];
                     reg_re_d    = byte_in[0];
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end

            // First scl fall starts the ACK, the second ends it and begins the data phase.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WRITE_ACK: if (scl_fall) begin
               if (!sda_oe_q) begin
                  sda_oe_d = 1'b1;
                  if (state_q == ST_WRITE_ACK) reg_addr_d = reg_addr_q + 8'd1;
               end else begin
                  bit_cnt_d = '0;
                  if (state_q == ST_ADDR_ACK && rw_q) begin
                     state_d  = ST_READ;
                     sda_oe_d = ~shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b1};
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WRITE;
                  end
               end
            end

            ST_PTR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  reg_addr_d = byte_in;
                  state_d    = ST_PTR_ACK;
               end
            end

            ST_WRITE: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  reg_wdata_d = byte_in;
                  reg_we_d    = 1'b1;
                  state_d     = ST_WRITE_ACK;
               end
            end

            ST_READ: begin
               if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
               if (scl_fall) begin
                  if (bit_cnt_q == BYTE_DONE) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = ST_READ_ACK;
                  end else begin
                     sda_oe_d = ~shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b1};
                  end
               end
            end

            ST_READ_ACK: if (scl_rise) begin
               if (sda_s == I2C_ACK) begin
                  reg_addr_d = reg_addr_q + 8'd1;
                  reg_re_d   = 1'b1;
                  bit_cnt_d  = '0;
                  state_d    = ST_READ;
               end else begin
                  state_d = ST_WAIT;
               end
            end

            default: ;
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         sda_oe_q    <= 1'b0;
         rw_q        <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         rd_load_q   <= 1'b0;
         busy_q      <= 1'b0;
         addressed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         sda_oe_q    <= sda_oe_d;
         rw_q        <= rw_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         rd_load_q   <= rd_load_d;
         busy_q      <= busy_d;
         addressed_q <= addressed_d;
      end
   end

   assign sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_we    = reg_we_q;
   assign reg_re    = reg_re_q;
   assign busy      = busy_q;
   assign addressed = addressed_q;
   assign state     = state_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: bit-level I2C master BFM, pullup and a registered host model.
module tb_i2c_slave_regs;

   localparam int Q = 8;   // clk cycles per quarter scl period

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       m_oe;
   wire        sda;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, reg_re, busy, addressed;
   logic [3:0] state;

   pullup (sda);
   assign sda = m_oe ? 1'b0 : 1'bz;

   i2c_slave_regs #(.SLAVE_ADDR(7'h77), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .scl(scl), .sda(sda),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy), .addressed(addressed), .state(state)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   logic [7:0] mem [256];
   logic [7:0] we_addr_log [64];
   logic [7:0] we_data_log [64];
   logic [7:0] re_addr_log [64];
   logic [5:0] we_cnt = '0;
   logic [5:0] re_cnt = '0;
   logic [5:0] both_cnt = '0;

   // Host model: logs pulses and returns mem data the clk after reg_re.
   always @(posedge clk) begin
      if (reg_we) begin
         we_addr_log[we_cnt] <= reg_addr;
         we_data_log[we_cnt] <= reg_wdata;
         we_cnt <= we_cnt + 6'd1;
      end
      if (reg_re) begin
         re_addr_log[re_cnt] <= reg_addr;
         re_cnt <= re_cnt + 6'd1;
         reg_rdata <= mem[reg_addr];
      end
      if (reg_we && reg_re) both_cnt <= both_cnt + 6'd1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start;
      m_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q);
      m_oe = 1'b1; tick(Q); scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop;
      m_oe = 1'b1; tick(Q); scl = 1'b1; tick(Q);
      m_oe = 1'b0; tick(Q);
   endtask

   task automatic write_bit(input logic b);
      m_oe = ~b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      m_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q);
      ack = sda; tick(Q); scl = 1'b0; tick(Q);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack_bit);
      d = '0;
      for (int i = 0; i < 8; i++) begin
         m_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q);
         d = {d[6:0], sda}; tick(Q); scl = 1'b0; tick(Q);
      end
      write_bit(ack_bit);
   endtask

   task automatic test_reset;
      nvec++; if (state !== 4'd0) begin nmis++; $display("FAIL reset_state: got %0d want 0", state); end
      nvec++; if (reg_addr !== 8'h00) begin nmis++; $display("FAIL reset_addr: got %h want 00", reg_addr); end
      nvec++; if (reg_wdata !== 8'h00) begin nmis++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
      nvec++; if ({reg_we, reg_re} !== 2'b00) begin nmis++; $display("FAIL reset_pulses: got %b want 00", {reg_we, reg_re}); end
      nvec++; if ({busy, addressed} !== 2'b00) begin nmis++; $display("FAIL reset_flags: got %b want 00", {busy, addressed}); end
      nvec++; if (sda !== 1'b1) begin nmis++; $display("FAIL reset_sda: got %b want 1", sda); end
   endtask

   task automatic test_write;
      logic a0, a1, a2;
      logic [5:0] we0, re0;
      we0 = we_cnt; re0 = re_cnt;
      i2c_start;
      write_byte(8'hEE, a0);
      write_byte(8'hF4, a1);
      write_byte(8'h2E, a2);
      nvec++; if ({a0, a1, a2} !== 3'b000) begin nmis++; $display("FAIL wr_acks: got %b want 000", {a0, a1, a2}); end
      nvec++; if ({busy, addressed} !== 2'b11) begin nmis++; $display("FAIL wr_flags_mid: got %b want 11", {busy, addressed}); end
      i2c_stop;
      tick(4);
      nvec++; if (we_cnt - we0 !== 6'd1) begin nmis++; $display("FAIL wr_we_count: got %0d want 1", we_cnt - we0); end
      nvec++; if ({we_addr_log[we0], we_data_log[we0]} !== 16'hF42E) begin nmis++; $display("FAIL wr_we_data: got %h want f42e", {we_addr_log[we0], we_data_log[we0]}); end
      nvec++; if (re_cnt !== re0) begin nmis++; $display("FAIL wr_no_re: got %0d want %0d", re_cnt, re0); end
      nvec++; if ({busy, addressed} !== 2'b00) begin nmis++; $display("FAIL wr_flags_stop: got %b want 00", {busy, addressed}); end
      nvec++; if (reg_addr !== 8'hF5) begin nmis++; $display("FAIL wr_ptr_inc: got %h want f5", reg_addr); end
   endtask

   task automatic test_id_read;
      logic a0, a1, a2;
      logic [7:0] d;
      logic [5:0] re0;
      re0 = re_cnt;
      i2c_start;
      write_byte(8'hEE, a0);
      write_byte(8'hD0, a1);
      i2c_start;
      write_byte(8'hEF, a2);
      read_byte(d, 1'b1);
      nvec++; if ({a0, a1, a2} !== 3'b000) begin nmis++; $display("FAIL id_acks: got %b want 000", {a0, a1, a2}); end
      nvec++; if (d !== 8'h55) begin nmis++; $display("FAIL id_data: got %h want 55", d); end
      nvec++; if (state !== 4'd9) begin nmis++; $display("FAIL id_wait_state: got %0d want 9", state); end
      i2c_stop;
      tick(4);
      nvec++; if (re_cnt - re0 !== 6'd1) begin nmis++; $display("FAIL id_re_count: got %0d want 1", re_cnt - re0); end
      nvec++; if (re_addr_log[re0] !== 8'hD0) begin nmis++; $display("FAIL id_re_addr: got %h want d0", re_addr_log[re0]); end
      nvec++; if (reg_addr !== 8'hD0) begin nmis++; $display("FAIL id_ptr_after_nack: got %h want d0", reg_addr); end
      nvec++; if ({sda, state} !== 5'b1_0000) begin nmis++; $display("FAIL id_released: got sda=%b st=%0d want sda=1 st=0", sda, state); end
   endtask

   task automatic test_burst_read;
      logic a0, a1, a2;
      logic [7:0] d0, d1, d2;
      logic [5:0] re0;
      re0 = re_cnt;
      i2c_start;
      write_byte(8'hEE, a0);
      write_byte(8'hF6, a1);
      i2c_start;
      write_byte(8'hEF, a2);
      read_byte(d0, 1'b0);
      read_byte(d1, 1'b0);
      read_byte(d2, 1'b1);
      i2c_stop;
      tick(4);
      nvec++; if ({a0, a1, a2} !== 3'b000) begin nmis++; $display("FAIL burst_acks: got %b want 000", {a0, a1, a2}); end
      nvec++; if ({d0, d1, d2} !== 24'hA13C7E) begin nmis++; $display("FAIL burst_data: got %h want a13c7e", {d0, d1, d2}); end
      nvec++; if (re_cnt - re0 !== 6'd3) begin nmis++; $display("FAIL burst_re_count: got %0d want 3", re_cnt - re0); end
      nvec++; if ({re_addr_log[re0], re_addr_log[re0+6'd1], re_addr_log[re0+6'd2]} !== 24'hF6F7F8) begin
         nmis++; $display("FAIL burst_re_addrs: got %h %h %h want f6 f7 f8", re_addr_log[re0], re_addr_log[re0+6'd1], re_addr_log[re0+6'd2]);
      end
   endtask

   task automatic test_bad_addr;
      logic a0, a1, a2;
      logic [5:0] we0, re0;
      we0 = we_cnt; re0 = re_cnt;
      i2c_start;
      write_byte(8'h78, a0);
      nvec++; if (a0 !== 1'b1) begin nmis++; $display("FAIL bad_nack: got %b want 1", a0); end
      nvec++; if ({busy, addressed, state} !== 6'b10_0000) begin nmis++; $display("FAIL bad_flags: got b=%b a=%b st=%0d want b=1 a=0 st=0", busy, addressed, state); end
      write_byte(8'h12, a1);
      i2c_stop;
      tick(4);
      nvec++; if ({we_cnt, re_cnt} !== {we0, re0}) begin nmis++; $display("FAIL bad_no_pulses: got we=%0d re=%0d want we=%0d re=%0d", we_cnt, re_cnt, we0, re0); end
      i2c_start;
      write_byte(8'hEE, a2);
      write_byte(8'h10, a1);
      i2c_stop;
      nvec++; if (a2 !== 1'b0) begin nmis++; $display("FAIL bad_then_good_ack: got %b want 0", a2); end
   endtask

   task automatic test_wrap;
      logic a0, a1, a2, a3;
      logic [5:0] we0;
      we0 = we_cnt;
      i2c_start;
      write_byte(8'hEE, a0);
      write_byte(8'hFF, a1);
      write_byte(8'h11, a2);
      write_byte(8'h22, a3);
      i2c_stop;
      tick(4);
      nvec++; if ({a0, a1, a2, a3} !== 4'b0000) begin nmis++; $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
      nvec++; if (we_cnt - we0 !== 6'd2) begin nmis++; $display("FAIL wrap_we_count: got %0d want 2", we_cnt - we0); end
      nvec++; if ({we_addr_log[we0], we_data_log[we0], we_addr_log[we0+6'd1], we_data_log[we0+6'd1]} !== 32'hFF11_0022) begin
         nmis++; $display("FAIL wrap_we_data: got %h%h_%h%h want ff11_0022", we_addr_log[we0], we_data_log[we0], we_addr_log[we0+6'd1], we_data_log[we0+6'd1]);
      end
      nvec++; if (reg_addr !== 8'h01) begin nmis++; $display("FAIL wrap_ptr: got %h want 01", reg_addr); end
   endtask

   task automatic test_reset_mid_read;
      logic a0, a1, a2;
      i2c_start;
      write_byte(8'hEE, a0);
      write_byte(8'hD0, a1);
      i2c_start;
      write_byte(8'hEF, a2);
      // scl low, target now drives the MSB (0) of 0x55
      nvec++; if ({sda, state} !== 5'b0_0111) begin nmis++; $display("FAIL rst_pre_drive: got sda=%b st=%0d want sda=0 st=7", sda, state); end
      reset = 1'b0;
      tick(1);
      nvec++; if ({sda, state, busy, addressed} !== 7'b1_0000_00) begin
         nmis++; $display("FAIL rst_abort: got sda=%b st=%0d b=%b a=%b want sda=1 st=0 b=0 a=0", sda, state, busy, addressed);
      end
      reset = 1'b1;
      tick(2);
      i2c_stop;
      tick(4);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[8'hD0] = 8'h55;
      mem[8'hF6] = 8'hA1;
      mem[8'hF7] = 8'h3C;
      mem[8'hF8] = 8'h7E;
      reset = 1'b0; scl = 1'b1; m_oe = 1'b0;
      tick(4);
      test_reset;
      reset = 1'b1;
      tick(4);
      test_write;
      test_id_read;
      test_burst_read;
      test_bad_addr;
      test_wrap;
      test_reset_mid_read;
      test_id_read;
      nvec++; if (both_cnt !== 6'd0) begin nmis++; $display("FAIL we_re_overlap: got %0d want 0", both_cnt); end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
